// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory port arbiter: owner encoding
// and default starvation limit.
package imem_arb_pkg;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W_DEF   = 4;

endpackage

// File: rtl/imem_arb_prio.sv
// Fixed IF-over-LS priority selector with an LS starvation counter that
// forces an LS grant once LS has waited MAX_WAIT consecutive cycles.
module imem_arb_prio
    import imem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int WAIT_W   = WAIT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic ls_valid,
    input  logic slot_free,
    input  logic ls_fire,
    output logic grant_ls
);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_starved;

    assign w_starved = (r_wait_cnt >= WAIT_W'(MAX_WAIT));
    assign grant_ls  = slot_free & ls_valid & (~if_valid | w_starved);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!ls_valid || ls_fire) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != {WAIT_W{1'b1}}) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port imem between instruction fetch and the load/debug
// port; tracks the one-cycle read latency and holds the address on stalls.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int WAIT_W   = WAIT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_req_addr,
    output logic        ls_rsp_valid,
    input  logic        ls_rsp_ready,
    output logic [31:0] ls_rsp_data,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd_data
);

    logic        r_rsp_valid;
    logic        r_rsp_owner;
    logic [31:0] r_last_addr;

    logic w_owner_rsp_fire;
    logic w_slot_free;
    logic w_grant_ls;
    logic w_if_fire;
    logic w_ls_fire;
    logic w_req_fire;

    assign w_owner_rsp_fire = r_rsp_valid &
        ((r_rsp_owner == OWN_IF) ? if_rsp_ready : ls_rsp_ready);
    assign w_slot_free = ~rst & (~r_rsp_valid | w_owner_rsp_fire);

    imem_arb_prio #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_prio (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_req_valid),
        .ls_valid  (ls_req_valid),
        .slot_free (w_slot_free),
        .ls_fire   (w_ls_fire),
        .grant_ls  (w_grant_ls)
    );

    assign ls_req_ready = w_grant_ls;
    assign if_req_ready = w_slot_free & if_req_valid & ~w_grant_ls;

    assign w_if_fire  = if_req_valid & if_req_ready;
    assign w_ls_fire  = ls_req_valid & ls_req_ready;
    assign w_req_fire = w_if_fire | w_ls_fire;

    // Outside a fire cycle the last fired address is replayed so imem keeps
    // returning the same word while a response is back-pressured.
    always_comb begin
        mem_addr = r_last_addr;
        if (rst) begin
            mem_addr = '0;
        end else if (w_ls_fire) begin
            mem_addr = ls_req_addr;
        end else if (w_if_fire) begin
            mem_addr = if_req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= OWN_IF;
            r_last_addr <= '0;
        end else if (w_req_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_owner <= w_ls_fire ? OWN_LS : OWN_IF;
            r_last_addr <= mem_addr;
        end else if (w_owner_rsp_fire) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign if_rsp_valid = ~rst & r_rsp_valid & (r_rsp_owner == OWN_IF);
    assign ls_rsp_valid = ~rst & r_rsp_valid & (r_rsp_owner == OWN_LS);
    assign if_rsp_data  = mem_rd_data;
    assign ls_rsp_data  = mem_rd_data;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a registered-address imem model.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
    logic        ls_req_valid, ls_req_ready, ls_rsp_valid, ls_rsp_ready;
    logic [31:0] if_req_addr, if_rsp_data, ls_req_addr, ls_rsp_data;
    logic [31:0] mem_addr, mem_rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mw(input logic [7:0] idx);
        return {24'hA5C3E1, idx};
    endfunction

    // imem: address sampled on clk, word data one cycle later
    always @(posedge clk) mem_rd_data <= mw(mem_addr[9:2]);

    imem_port_arbiter #(.MAX_WAIT(4), .WAIT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .ls_req_valid (ls_req_valid),
        .ls_req_ready (ls_req_ready),
        .ls_req_addr  (ls_req_addr),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rsp_ready (ls_rsp_ready),
        .ls_rsp_data  (ls_rsp_data),
        .mem_addr     (mem_addr),
        .mem_rd_data  (mem_rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the edge, outputs sampled 2 after
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic prev_ls;
        logic exp_ls;

        rst = 1'b1;
        if_req_valid = 1'b1; if_req_addr = 32'h0;
        ls_req_valid = 1'b1; ls_req_addr = 32'h100;
        if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1;
        cyc(); cyc(); settle();
        chk("rst_if_req_ready", {31'b0, if_req_ready}, 32'd0);
        chk("rst_ls_req_ready", {31'b0, ls_req_ready}, 32'd0);
        chk("rst_if_rsp_valid", {31'b0, if_rsp_valid}, 32'd0);
        chk("rst_ls_rsp_valid", {31'b0, ls_rsp_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);

        // IF-only stream 0x0, 0x4, 0x8
        cyc();
        rst = 1'b0; ls_req_valid = 1'b0; if_req_addr = 32'h0;
        settle();
        chk("s1_ready0", {31'b0, if_req_ready}, 32'd1);
        chk("s1_maddr0", mem_addr, 32'h0);
        cyc(); if_req_addr = 32'h4; settle();
        chk("s1_ready1", {31'b0, if_req_ready}, 32'd1);
        chk("s1_vld0", {31'b0, if_rsp_valid}, 32'd1);
        chk("s1_data0", if_rsp_data, mw(8'd0));
        chk("s1_maddr1", mem_addr, 32'h4);
        cyc(); if_req_addr = 32'h8; settle();
        chk("s1_data1", if_rsp_data, mw(8'd1));
        chk("s1_ls_vld", {31'b0, ls_rsp_valid}, 32'd0);
        cyc(); if_req_valid = 1'b0; settle();
        chk("s1_vld2", {31'b0, if_rsp_valid}, 32'd1);
        chk("s1_data2", if_rsp_data, mw(8'd2));
        chk("s1_idle_ready", {31'b0, if_req_ready}, 32'd0);
        cyc(); settle();
        chk("s1_drain", {31'b0, if_rsp_valid}, 32'd0);
        chk("s1_hold_addr", mem_addr, 32'h8);

        // both valid: IF wins 4 cycles, LS forced on the 5th, repeating
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        ls_req_valid = 1'b1; ls_req_addr = 32'h100;
        prev_ls = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) cyc();
            settle();
            exp_ls = ((k % 5) == 4);
            chk($sformatf("s2_ls_ready_k%0d", k), {31'b0, ls_req_ready}, {31'b0, exp_ls});
            chk($sformatf("s2_if_ready_k%0d", k), {31'b0, if_req_ready}, {31'b0, ~exp_ls});
            chk($sformatf("s2_maddr_k%0d", k), mem_addr, exp_ls ? 32'h100 : 32'h10);
            if (k > 0) begin
                chk($sformatf("s2_ls_vld_k%0d", k), {31'b0, ls_rsp_valid}, {31'b0, prev_ls});
                chk($sformatf("s2_data_k%0d", k), if_rsp_data, prev_ls ? mw(8'd64) : mw(8'd4));
            end
            prev_ls = exp_ls;
        end
        cyc(); if_req_valid = 1'b0; ls_req_valid = 1'b0; settle();
        chk("s2_last_ls_vld", {31'b0, ls_rsp_valid}, 32'd1);
        chk("s2_last_ls_data", ls_rsp_data, mw(8'd64));
        cyc(); settle();
        chk("s2_idle_if_vld", {31'b0, if_rsp_valid}, 32'd0);
        chk("s2_idle_ls_vld", {31'b0, ls_rsp_valid}, 32'd0);

        // LS fire to 0x100, response stalled 3 cycles with IF waiting
        ls_req_valid = 1'b1; ls_req_addr = 32'h100; ls_rsp_ready = 1'b0;
        settle();
        chk("s3_ls_ready", {31'b0, ls_req_ready}, 32'd1);
        chk("s3_maddr_fire", mem_addr, 32'h100);
        cyc(); ls_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h30;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) cyc();
            settle();
            chk($sformatf("s3_ls_vld_s%0d", s), {31'b0, ls_rsp_valid}, 32'd1);
            chk($sformatf("s3_ls_data_s%0d", s), ls_rsp_data, mw(8'd64));
            chk($sformatf("s3_maddr_s%0d", s), mem_addr, 32'h100);
            chk($sformatf("s3_if_ready_s%0d", s), {31'b0, if_req_ready}, 32'd0);
            chk($sformatf("s3_if_vld_s%0d", s), {31'b0, if_rsp_valid}, 32'd0);
        end
        cyc(); ls_rsp_ready = 1'b1; settle();
        chk("s3_release_ls_vld", {31'b0, ls_rsp_valid}, 32'd1);
        chk("s3_release_if_ready", {31'b0, if_req_ready}, 32'd1);
        chk("s3_release_maddr", mem_addr, 32'h30);
        cyc(); if_req_valid = 1'b0; settle();
        chk("s3_if_vld", {31'b0, if_rsp_valid}, 32'd1);
        chk("s3_if_data", if_rsp_data, mw(8'd12));
        chk("s3_ls_clear", {31'b0, ls_rsp_valid}, 32'd0);

        // stalled IF response accepted in the same cycle the next IF fires
        cyc(); if_req_valid = 1'b1; if_req_addr = 32'h20; if_rsp_ready = 1'b0; settle();
        chk("s4_fire0", {31'b0, if_req_ready}, 32'd1);
        cyc(); if_req_addr = 32'h24; settle();
        chk("s4_stall_ready", {31'b0, if_req_ready}, 32'd0);
        chk("s4_stall_data", if_rsp_data, mw(8'd8));
        cyc(); if_rsp_ready = 1'b1; settle();
        chk("s4_swap_ready", {31'b0, if_req_ready}, 32'd1);
        chk("s4_swap_vld", {31'b0, if_rsp_valid}, 32'd1);
        chk("s4_swap_data", if_rsp_data, mw(8'd8));
        cyc(); if_req_valid = 1'b0; settle();
        chk("s4_next_vld", {31'b0, if_rsp_valid}, 32'd1);
        chk("s4_next_data", if_rsp_data, mw(8'd9));

        // reset while an LS response is pending
        cyc(); ls_req_valid = 1'b1; ls_req_addr = 32'h100; ls_rsp_ready = 1'b0; settle();
        chk("s5_ls_fire", {31'b0, ls_req_ready}, 32'd1);
        cyc(); ls_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h40; rst = 1'b1; settle();
        chk("s5_rst_ls_vld", {31'b0, ls_rsp_valid}, 32'd0);
        chk("s5_rst_if_ready", {31'b0, if_req_ready}, 32'd0);
        chk("s5_rst_maddr", mem_addr, 32'h0);
        cyc(); rst = 1'b0; if_req_valid = 1'b0; settle();
        chk("s5_post_ls_vld", {31'b0, ls_rsp_valid}, 32'd0);
        chk("s5_post_if_vld", {31'b0, if_rsp_valid}, 32'd0);
        chk("s5_post_maddr", mem_addr, 32'h0);
        cyc(); if_req_valid = 1'b1; if_rsp_ready = 1'b1; ls_rsp_ready = 1'b1; settle();
        chk("s5_if_ready", {31'b0, if_req_ready}, 32'd1);
        chk("s5_if_maddr", mem_addr, 32'h40);
        cyc(); if_req_valid = 1'b0; settle();
        chk("s5_if_vld", {31'b0, if_rsp_valid}, 32'd1);
        chk("s5_if_data", if_rsp_data, mw(8'd16));
        chk("s5_ls_none", {31'b0, ls_rsp_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
